// File: rtl/uart_program_loader_pkg.sv
// loader_pkg: shared constants and state types for the UART program loader.
//   HEADER_BYTE  - first byte of every program image
//   load_state_e - framing FSM states
//   rx_state_e   - byte receiver states
package loader_pkg;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } load_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: IMEM write port between the loader and instruction memory.
//   imem_we    - one-cycle write strobe
//   imem_addr  - word address
//   imem_wdata - write data
//   master: driven by the loader; slave: seen by the IMEM.
interface uart_program_loader_if #(
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (output imem_we, imem_addr, imem_wdata);
   modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_program_loader_rx_byte.sv
// uart_rx_byte: 2-flop synchronizer plus 8N1 byte receiver, LSB first.
//   clk, reset   - system clock, synchronous active-high reset
//   uart_rx_i    - asynchronous serial line, idle high
//   rx_valid_o   - one-cycle pulse with rx_byte_o on a good stop bit
//   rx_byte_o    - received byte
//   frame_err_o  - one-cycle pulse when the stop bit reads 0
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_byte_o,
   output logic       frame_err_o
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);

   logic          sync1_q, sync2_q, prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;

   logic half_tick, bit_tick;
   assign half_tick = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
   assign bit_tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync1_q <= uart_rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
         // A line that is high again at mid start bit was only a glitch.
         RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_tick && bit_q == 3'd7) state_d = RX_STOP;
         RX_STOP:  if (bit_tick) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE:  cnt_d = '0;
         RX_START: if (half_tick) begin
            cnt_d = '0;
            bit_d = '0;
         end
         RX_DATA:  if (bit_tick) begin
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            shift_d = {sync2_q, shift_q[7:1]};
         end
         RX_STOP:  if (bit_tick) cnt_d = '0;
         default:  cnt_d = '0;
      endcase
      rx_valid_o  = (state_q == RX_STOP) && bit_tick && sync2_q;
      frame_err_o = (state_q == RX_STOP) && bit_tick && !sync2_q;
      rx_byte_o   = shift_q;
   end

endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a program image over UART and writes it to IMEM,
// holding the processor in reset until a checksum-verified image has landed.
//   clk, reset      - system clock, synchronous active-high reset
//   uart_rx         - serial input, 8N1, idle high
//   imem            - IMEM write port (master)
//   cpu_reset_hold  - processor reset request
//   load_done       - sticky: last load succeeded
//   load_error      - sticky: last load failed
//   frame_err       - one-cycle pulse on a bad stop bit
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT   = 868,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   uart_program_loader_if.master imem,
   output logic                  cpu_reset_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic                  frame_err
);

   localparam int unsigned WIDX_W = ADDR_WIDTH + 1;
   localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);

   logic       rx_valid, rx_ferr;
   logic [7:0] rx_byte;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk),
      .reset       (reset),
      .uart_rx_i   (uart_rx),
      .rx_valid_o  (rx_valid),
      .rx_byte_o   (rx_byte),
      .frame_err_o (rx_ferr)
   );

   load_state_e           state_q, state_d;
   logic [7:0]            cnt_lo_q, cnt_lo_d;
   logic [WIDX_W-1:0]     words_q, words_d;
   logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
   logic [7:0]            csum_q, csum_d;
   logic [31:0]           word_q, word_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic                  wr_pend_q, wr_pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  hold_q, hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [TW-1:0]         tmo_q, tmo_d;

   logic [15:0] count;
   logic        oversize, last_word, timeout;
   assign count     = {rx_byte, cnt_lo_q};
   assign oversize  = {16'd0, count} > (32'd1 << ADDR_WIDTH);
   assign last_word = (word_idx_q + WIDX_W'(1)) == words_q;
   assign timeout   = tmo_q >= TW'(TIMEOUT_CYCLES);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_lo_q   <= '0;
         words_q    <= '0;
         word_idx_q <= '0;
         csum_q     <= '0;
         word_q     <= '0;
         byte_idx_q <= '0;
         wr_pend_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_lo_q   <= cnt_lo_d;
         words_q    <= words_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         wr_pend_q  <= wr_pend_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (rx_valid && rx_byte == HEADER_BYTE) state_d = CNT_LO;
         CNT_LO: if (rx_valid) state_d = CNT_HI;
         CNT_HI: if (rx_valid) begin
            if (oversize)            state_d = ERROR;
            else if (count == 16'd0) state_d = CSUM;
            else                     state_d = DATA;
         end
         // Leave DATA on the write cycle of the last word so imem_we stays inside DATA.
         DATA:   if (wr_pend_q && last_word) state_d = CSUM;
         CSUM:   if (rx_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
         default: state_d = IDLE;
      endcase
      if ((state_q inside {CNT_LO, CNT_HI, DATA, CSUM}) && (rx_ferr || timeout))
         state_d = ERROR;
   end

   always_comb begin
      cnt_lo_d   = cnt_lo_q;
      words_d    = words_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      wr_pend_d  = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      tmo_d      = (rx_valid || (state_q inside {IDLE, DONE, ERROR})) ? '0 : tmo_q + TW'(1);
      case (state_q)
         IDLE: if (rx_valid && rx_byte == HEADER_BYTE) begin
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
            csum_d = '0;
         end
         CNT_LO: if (rx_valid) begin
            cnt_lo_d = rx_byte;
            csum_d   = csum_q ^ rx_byte;
         end
         CNT_HI: if (rx_valid) begin
            words_d    = WIDX_W'(count);
            csum_d     = csum_q ^ rx_byte;
            byte_idx_d = '0;
            word_idx_d = '0;
         end
         DATA: begin
            if (rx_valid) begin
               csum_d                    = csum_q ^ rx_byte;
               word_d[8*byte_idx_q +: 8] = rx_byte;
               byte_idx_d                = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wr_pend_d = 1'b1;
                  addr_d    = word_idx_q[ADDR_WIDTH-1:0];
                  wdata_d   = {rx_byte, word_q[23:0]};
               end
            end
            if (wr_pend_q) word_idx_d = word_idx_q + WIDX_W'(1);
         end
         DONE: begin
            done_d = 1'b1;
            hold_d = 1'b0;
         end
         ERROR: err_d = 1'b1;
         default: ;
      endcase
   end

   assign imem.imem_we    = wr_pend_q;
   assign imem.imem_addr  = addr_q;
   assign imem.imem_wdata = wdata_q;
   assign cpu_reset_hold  = hold_q;
   assign load_done       = done_q;
   assign load_error      = err_q;
   assign frame_err       = rx_ferr;

endmodule
